// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute side bundle for the branch resolve queue: prediction push,
// in-order resolve, pipeline flush and the predictor-table update port.
interface branch_resolve_queue_if #(
    parameter int IDX_W = 8
) ();
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_index;
    logic             prediction;
    logic             resolve_valid;
    logic             taken;
    logic             flush;
    logic             set;
    logic [IDX_W-1:0] set_index;
    logic             feedback;
    logic             mispredict;

    modport master (
        output pred_valid, pred_index, prediction, resolve_valid, taken, flush,
        input  pred_ready, set, set_index, feedback, mispredict
    );

    modport slave (
        input  pred_valid, pred_index, prediction, resolve_valid, taken, flush,
        output pred_ready, set, set_index, feedback, mispredict
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; drives the 2-bit counter table update.
// Optional macro BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    branch_resolve_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]              stat_resolved,
    output logic [15:0]              stat_mispredict
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             pred;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             rd_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               miss;

    logic               set_r;
    logic [IDX_W-1:0]   set_index_r;
    logic               feedback_r;
    logic               mispredict_r;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A push racing a flush is squashed along with everything already queued.
    assign push     = bus.pred_valid && !full && !bus.flush;
    // No bypass: an entry pushed this cycle is not visible to a resolve until next cycle.
    assign pop      = bus.resolve_valid && !empty;
    assign rd_entry = mem[rd_ptr];
    assign miss     = pop && (rd_entry.pred != bus.taken);

    assign bus.pred_ready = !full;
    assign bus.set        = set_r;
    assign bus.set_index  = set_index_r;
    assign bus.feedback   = feedback_r;
    assign bus.mispredict = mispredict_r;
    assign occupancy      = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{index: bus.pred_index, pred: bus.prediction};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Update strobe is registered even under flush so the resolving branch still trains the table.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            set_r        <= 1'b0;
            set_index_r  <= '0;
            feedback_r   <= 1'b0;
            mispredict_r <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            set_r        <= pop;
            mispredict_r <= miss;
            if (pop) begin
                set_index_r <= rd_entry.index;
                feedback_r  <= bus.taken;
            end
            if (bus.resolve_valid && empty) underflow <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (pop && stat_resolved != 16'hFFFF)
                stat_resolved <= stat_resolved + 16'd1;
            if (miss && stat_mispredict != 16'hFFFF)
                stat_mispredict <= stat_mispredict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: update pulses, ordering, wrap,
// underflow, flush and asynchronous reset, with hand-computed expectations.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic       clk;
    logic       reset_n;
    logic [2:0] occupancy;
    logic       underflow;
`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredict;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    branch_resolve_queue_if #(.IDX_W(IDX_W)) brq_bus ();

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (brq_bus.slave),
        .occupancy (occupancy),
        .underflow (underflow)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [7:0] idx, input logic pr,
                         input logic rv, input logic tk, input logic fl);
        brq_bus.pred_valid    = pv;
        brq_bus.pred_index    = idx;
        brq_bus.prediction    = pr;
        brq_bus.resolve_valid = rv;
        brq_bus.taken         = tk;
        brq_bus.flush         = fl;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_update(input string tag, input logic [7:0] idx,
                                input logic fb, input logic mp);
        check_val({tag, " set"}, brq_bus.set, 1);
        check_val({tag, " set_index"}, brq_bus.set_index, idx);
        check_val({tag, " feedback"}, brq_bus.feedback, fb);
        check_val({tag, " mispredict"}, brq_bus.mispredict, mp);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #2;
        check_val("rst set", brq_bus.set, 0);
        check_val("rst set_index", brq_bus.set_index, 0);
        check_val("rst feedback", brq_bus.feedback, 0);
        check_val("rst mispredict", brq_bus.mispredict, 0);
        check_val("rst occupancy", occupancy, 0);
        check_val("rst underflow", underflow, 0);
        check_val("rst pred_ready", brq_bus.pred_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // basic update
        drive(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("basic occ after push", occupancy, 1);
        check_val("basic no set", brq_bus.set, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_update("basic", 8'h05, 1'b0, 1'b1);
        idle();
        tick();
        check_val("basic set low", brq_bus.set, 0);
        check_val("basic mispredict low", brq_bus.mispredict, 0);
        check_val("basic occ 0", occupancy, 0);
        check_val("basic index held", brq_bus.set_index, 8'h05);

        // fill and order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), (i % 2 == 0), 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_val("fill occ", occupancy, 4);
        check_val("fill ready", brq_bus.pred_ready, 0);
        drive(1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("fill refused occ", occupancy, 4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            check_update($sformatf("order%0d", i), 8'(i), 1'b1, (i % 2 == 1));
        end
        idle();
        tick();
        check_val("order drained occ", occupancy, 0);
        check_val("order no idx9", brq_bus.set, 0);

        // wrap-around at occupancy 2
        drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h12 + k), 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            check_val($sformatf("wrap%0d occ", k), occupancy, 2);
            check_val($sformatf("wrap%0d idx", k), brq_bus.set_index, 8'h10 + k);
            check_val($sformatf("wrap%0d mp", k), brq_bus.mispredict, (k == 0) ? 1 : 0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_update("wrap drain0", 8'h1A, 1'b1, 1'b0);
        tick();
        check_update("wrap drain1", 8'h1B, 1'b1, 1'b0);
        idle();
        tick();
        check_val("wrap empty", occupancy, 0);

        // empty resolve with simultaneous push: push taken, pop not, underflow set
        drive(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("empty no set", brq_bus.set, 0);
        check_val("empty underflow", underflow, 1);
        check_val("empty push kept", occupancy, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_val("flush keeps underflow", underflow, 1);
        check_val("flush clears occ", occupancy, 0);

        // flush with resolve and push in the same cycle
        drive(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("flush pre occ", occupancy, 3);
        drive(1'b1, 8'hD4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_update("flush resolve", 8'hA1, 1'b1, 1'b0);
        check_val("flush occ", occupancy, 0);
        drive(1'b1, 8'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("flush set low", brq_bus.set, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_update("post flush", 8'hE5, 1'b0, 1'b1);

        // asynchronous reset with a set pulse pending
        drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_update("pre areset", 8'h31, 1'b1, 1'b1);
        check_val("pre areset occ", occupancy, 2);
        idle();
        #1;
        reset_n = 1'b0;
        #1;
        check_val("areset set", brq_bus.set, 0);
        check_val("areset set_index", brq_bus.set_index, 0);
        check_val("areset feedback", brq_bus.feedback, 0);
        check_val("areset mispredict", brq_bus.mispredict, 0);
        check_val("areset occ", occupancy, 0);
        check_val("areset underflow", underflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("post reset occ", occupancy, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_update("post reset", 8'h77, 1'b1, 1'b1);
        check_val("post reset occ0", occupancy, 0);
        check_val("post reset underflow", underflow, 0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
